// File: rtl/sb_rx_deserializer_pkg.sv
// sb_rx_deserializer_pkg: sideband word layout, clock patterns and pattern-search states
package sb_rx_deserializer_pkg;
  localparam int SB_PKT_W = 64;
  localparam logic [SB_PKT_W-1:0] SB_CLK_PATTERN_A = 64'h5555_5555_5555_5555;
  localparam logic [SB_PKT_W-1:0] SB_CLK_PATTERN_B = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam int SB_CP_BIT = 63;
  localparam int SB_DP_BIT = 62;
  localparam int SB_OPCODE_MSB = 4;
  localparam int SB_OPCODE_LSB = 0;
  localparam int SB_MSGCODE_MSB = 21;
  localparam int SB_MSGCODE_LSB = 14;
  typedef enum logic {SB_SEARCH = 1'b0, SB_LOCKED = 1'b1} sb_pat_state_e;
  function automatic logic sb_parity_err(input logic [SB_PKT_W-1:0] w);
    return (^w[SB_DP_BIT-1:0]) != w[SB_CP_BIT];
  endfunction
endpackage

// File: rtl/sb_rx_deserializer_if.sv
// sb_rx_deserializer_if: control, serial input and word/pattern outputs of the SB receiver
interface sb_rx_deserializer_if
  import sb_rx_deserializer_pkg::*;
#(
  parameter int PKT_W = SB_PKT_W,
  parameter int ERR_CNT_W = 8
);
  logic enable_i;
  logic mode_i;
  logic SB_dataPin_RX_i;
  logic pattern_detect_o;
  logic pattern_lock_o;
  logic [PKT_W-1:0] pkt_data_o;
  logic pkt_toggle_o;
  logic pkt_parity_err_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;
  modport master(
    output enable_i, mode_i, SB_dataPin_RX_i,
    input pattern_detect_o, pattern_lock_o, pkt_data_o, pkt_toggle_o, pkt_parity_err_o, err_cnt_o
  );
  modport slave(
    input enable_i, mode_i, SB_dataPin_RX_i,
    output pattern_detect_o, pattern_lock_o, pkt_data_o, pkt_toggle_o, pkt_parity_err_o, err_cnt_o
  );
endinterface

// File: rtl/sb_rx_deserializer_pattern_detector.sv
// sb_pattern_detector: non-overlapping 64-UI clock-pattern search with consecutive-hit lock
module sb_pattern_detector
  import sb_rx_deserializer_pkg::*;
#(
  parameter int PKT_W = SB_PKT_W,
  parameter int PATTERN_LOCK_CNT = 2
) (
  input  logic             clk_800MHz,
  input  logic             reset_n,
  input  logic             active_i,
  input  logic [PKT_W-1:0] next_sr_i,
  output logic             detect_o,
  output logic             lock_o
);
  localparam int FW = $clog2(PKT_W);
  localparam int KW = $clog2(PATTERN_LOCK_CNT + 1);
  sb_pat_state_e state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [KW-1:0] consec_q, consec_d;
  logic detect_q, detect_d;
  logic full, hit;
  always_comb begin
    full = &fill_q;
    hit = active_i && full && (next_sr_i == SB_CLK_PATTERN_A || next_sr_i == SB_CLK_PATTERN_B);
    detect_d = hit;
    fill_d = (!active_i || hit) ? '0 : full ? fill_q : fill_q + 1'b1;
    consec_d = !active_i ? '0
             : hit ? ((consec_q == KW'(PATTERN_LOCK_CNT)) ? consec_q : consec_q + 1'b1)
             : full ? '0 : consec_q;
    state_d = !active_i ? SB_SEARCH : (consec_d == KW'(PATTERN_LOCK_CNT)) ? SB_LOCKED : state_q;
  end
  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SB_SEARCH;
      fill_q <= '0;
      consec_q <= '0;
      detect_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      consec_q <= consec_d;
      detect_q <= detect_d;
    end
  end
  assign detect_o = detect_q;
  assign lock_o = state_q == SB_LOCKED;
endmodule

// File: rtl/sb_rx_deserializer.sv
// sb_rx_deserializer: SB data pin to 64-bit words with toggle handoff, plus SBINIT pattern lock
module sb_rx_deserializer
  import sb_rx_deserializer_pkg::*;
#(
  parameter int PKT_W = SB_PKT_W,
  parameter int PATTERN_LOCK_CNT = 2,
  parameter int ERR_CNT_W = 8
) (
  input logic clk_800MHz,
  input logic reset_n,
  sb_rx_deserializer_if.slave sb
);
  localparam int CW = $clog2(PKT_W);
  logic mode_prev_q;
  logic [PKT_W-1:0] sr_q, sr_d, next_sr, pkt_data_q, pkt_data_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic pkt_toggle_q, pkt_toggle_d, pkt_parity_err_q, pkt_parity_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic clear, fire, perr, pat_active;
  always_comb begin
    clear = !sb.enable_i || (sb.mode_i != mode_prev_q);
    pat_active = !clear && !sb.mode_i;
    next_sr = {sb.SB_dataPin_RX_i, sr_q[PKT_W-1:1]};
    sr_d = clear ? sr_q : next_sr;
    bit_cnt_d = (clear || !sb.mode_i) ? '0 : bit_cnt_q + 1'b1;
    fire = !clear && sb.mode_i && (&bit_cnt_q);
    perr = sb_parity_err(next_sr);
    pkt_data_d = fire ? next_sr : pkt_data_q;
    pkt_toggle_d = fire ? !pkt_toggle_q : pkt_toggle_q;
    pkt_parity_err_d = fire ? perr : pkt_parity_err_q;
    err_cnt_d = (fire && perr && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      mode_prev_q <= 1'b0;
      sr_q <= '0;
      bit_cnt_q <= '0;
      pkt_data_q <= '0;
      pkt_toggle_q <= 1'b0;
      pkt_parity_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      mode_prev_q <= sb.mode_i;
      sr_q <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      pkt_data_q <= pkt_data_d;
      pkt_toggle_q <= pkt_toggle_d;
      pkt_parity_err_q <= pkt_parity_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  sb_pattern_detector #(.PKT_W(PKT_W), .PATTERN_LOCK_CNT(PATTERN_LOCK_CNT)) u_pat (
    .clk_800MHz(clk_800MHz),
    .reset_n(reset_n),
    .active_i(pat_active),
    .next_sr_i(next_sr),
    .detect_o(sb.pattern_detect_o),
    .lock_o(sb.pattern_lock_o)
  );
  assign sb.pkt_data_o = pkt_data_q;
  assign sb.pkt_toggle_o = pkt_toggle_q;
  assign sb.pkt_parity_err_o = pkt_parity_err_q;
  assign sb.err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_sb_rx_deserializer.sv
// tb_sb_rx_deserializer: vector table, directed corner sequences and random stream against a bit-queue model
module tb_sb_rx_deserializer;
  localparam int W = 64;
  localparam int EW = 8;
  localparam int LOCK = 2;
  localparam logic [63:0] PA = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PB = 64'hAAAA_AAAA_AAAA_AAAA;
  typedef struct {
    logic [63:0] word;
    logic        exp_tog;
    logic        exp_perr;
    logic [7:0]  exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sb_rx_deserializer_if #(.PKT_W(W), .ERR_CNT_W(EW)) sbi();
  sb_rx_deserializer #(.PKT_W(W), .PATTERN_LOCK_CNT(LOCK), .ERR_CNT_W(EW)) dut (
    .clk_800MHz(clk),
    .reset_n(rst_n),
    .sb(sbi)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  bit q[$];
  bit m_prev, m_det, m_lock, m_tog, m_perr;
  int m_n, m_last, m_consec, m_err;
  logic [63:0] m_data;
  vec_t vecs[7];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] window();
    logic [63:0] w;
    for (int i = 0; i < 64; i++) w[i] = q[q.size() - 64 + i];
    return w;
  endfunction
  task automatic model_reset();
    q.delete();
    m_prev = 0; m_det = 0; m_lock = 0; m_tog = 0; m_perr = 0;
    m_n = 0; m_last = 0; m_consec = 0; m_err = 0; m_data = '0;
  endtask
  task automatic model_step(input bit en, input bit md, input bit d);
    logic [63:0] w;
    bit clr;
    clr = !en || (md != m_prev);
    m_prev = md;
    m_det = 0;
    if (clr) begin
      q.delete(); m_n = 0; m_last = 0; m_consec = 0; m_lock = 0;
      return;
    end
    q.push_back(d);
    if (q.size() > 64) void'(q.pop_front());
    m_n++;
    if (!md) begin
      if (m_n - m_last >= 64) begin
        w = window();
        if (w == PA || w == PB) begin
          m_det = 1;
          m_last = m_n;
          if (m_consec < LOCK) m_consec++;
          if (m_consec >= LOCK) m_lock = 1;
        end else m_consec = 0;
      end
    end else if (m_n % 64 == 0) begin
      w = window();
      m_data = w;
      m_tog = !m_tog;
      m_perr = (^w[61:0]) != w[63];
      if (m_perr && m_err < 255) m_err++;
    end
  endtask
  task automatic compare_all();
    check("model_detect", 64'(sbi.pattern_detect_o), 64'(m_det));
    check("model_lock", 64'(sbi.pattern_lock_o), 64'(m_lock));
    check("model_data", sbi.pkt_data_o, m_data);
    check("model_toggle", 64'(sbi.pkt_toggle_o), 64'(m_tog));
    check("model_perr", 64'(sbi.pkt_parity_err_o), 64'(m_perr));
    check("model_errcnt", 64'(sbi.err_cnt_o), 64'(m_err));
  endtask
  task automatic tick(input bit en, input bit md, input bit d);
    sbi.enable_i = en;
    sbi.mode_i = md;
    sbi.SB_dataPin_RX_i = d;
    @(posedge clk);
    model_step(en, md, d);
    @(negedge clk);
    compare_all();
  endtask
  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 64; i++) tick(1, 1, w[i]);
  endtask
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_detect", 64'(sbi.pattern_detect_o), 64'd0);
    check("rst_lock", 64'(sbi.pattern_lock_o), 64'd0);
    check("rst_data", sbi.pkt_data_o, 64'd0);
    check("rst_toggle", 64'(sbi.pkt_toggle_o), 64'd0);
    check("rst_perr", 64'(sbi.pkt_parity_err_o), 64'd0);
    check("rst_errcnt", 64'(sbi.err_cnt_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [63:0] w1;
    bit saved_tog, md, pd, d;
    int k;
    vecs[0] = '{64'h0000_0000_0000_0000, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{64'h8000_0000_0000_0001, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{64'h0000_0000_0000_0001, 1'b1, 1'b1, 8'd1};
    vecs[3] = '{64'h4000_0000_0000_0000, 1'b0, 1'b0, 8'd1};
    vecs[4] = '{64'hC000_0000_0000_0003, 1'b1, 1'b1, 8'd2};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 8'd3};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 8'd3};
    sbi.enable_i = 0; sbi.mode_i = 0; sbi.SB_dataPin_RX_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick(1, 1, 1'($urandom % 2));
    pulse_reset();
    tick(1, 1, 0);
    foreach (vecs[i]) begin
      send_word(vecs[i].word);
      check("vec_data", sbi.pkt_data_o, vecs[i].word);
      check("vec_toggle", 64'(sbi.pkt_toggle_o), 64'(vecs[i].exp_tog));
      check("vec_perr", 64'(sbi.pkt_parity_err_o), 64'(vecs[i].exp_perr));
      check("vec_errcnt", 64'(sbi.err_cnt_o), 64'(vecs[i].exp_err));
    end
    tick(0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 1'($urandom % 2));
    tick(1, 0, 0);
    for (int j = 0; j < 192; j++) begin
      tick(1, 0, 1'(j % 2));
      check("p3_detect", 64'(sbi.pattern_detect_o), 64'(j + 6 == 69 || j + 6 == 133 || j + 6 == 197));
      check("p3_lock", 64'(sbi.pattern_lock_o), 64'(j + 6 >= 133));
    end
    tick(0, 0, 0);
    k = int'($urandom_range(0, 63));
    for (int j = 0; j < 256; j++) begin
      tick(1, 0, 1'((j % 2) ^ (j == 64 + k ? 1 : 0)));
      check("corr_detect", 64'(sbi.pattern_detect_o), 64'(j + 1 == 64 || j + 1 == 129 + k || j + 1 == 193 + k));
      check("corr_lock", 64'(sbi.pattern_lock_o), 64'(j + 1 >= 193 + k));
    end
    pulse_reset();
    tick(1, 1, 0);
    for (int p = 0; p < 256; p++) begin
      send_word(64'h0000_0000_0000_0001);
      if (p == 253) check("sat_254", 64'(sbi.err_cnt_o), 64'd254);
    end
    check("sat_errcnt", 64'(sbi.err_cnt_o), 64'd255);
    check("sat_perr", 64'(sbi.pkt_parity_err_o), 64'd1);
    w1 = {$urandom, $urandom};
    send_word(w1);
    saved_tog = m_tog;
    check("mc_word", sbi.pkt_data_o, w1);
    for (int i = 0; i < 20; i++) tick(1, 1, 1'($urandom % 2));
    tick(1, 0, 1);
    check("mc_toggle", 64'(sbi.pkt_toggle_o), 64'(saved_tog));
    for (int j = 0; j < 64; j++) begin
      tick(1, 0, 1'(j % 2));
      if (j == 62) check("mc_no_early_detect", 64'(sbi.pattern_detect_o), 64'd0);
    end
    check("mc_detect", 64'(sbi.pattern_detect_o), 64'd1);
    check("mc_data_kept", sbi.pkt_data_o, w1);
    check("mc_toggle_kept", 64'(sbi.pkt_toggle_o), 64'(saved_tog));
    md = 0; pd = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 300 == 0) md = !md;
      d = (!md && $urandom % 64 != 0) ? !pd : 1'($urandom % 2);
      pd = d;
      tick(1'($urandom % 40 != 0), md, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
